// File: rtl/ad9226_capture_if.sv
// Port bundle for the AD9226 capture block: ADC pins, capture control/status
// and the buffer read-back port.
interface ad9226_capture_if #(parameter int DATA_W = 12);
   logic              ADC_CLK;
   logic [DATA_W-1:0] ADC_Data;
   logic              ADC_OTR;
   logic              Start;
   logic              Trig_Mode;
   logic [DATA_W-1:0] Trig_Level;
   logic [15:0]       Decim;
   logic              Rd_en;
   logic [DATA_W-1:0] Rd_data;
   logic              Rd_valid;
   logic              Busy;
   logic              Done;
   logic              Ovr;

   modport slave (
      output ADC_CLK, Rd_data, Rd_valid, Busy, Done, Ovr,
      input  ADC_Data, ADC_OTR, Start, Trig_Mode, Trig_Level, Decim, Rd_en
   );

   modport master (
      input  ADC_CLK, Rd_data, Rd_valid, Busy, Done, Ovr,
      output ADC_Data, ADC_OTR, Start, Trig_Mode, Trig_Level, Decim, Rd_en
   );
endinterface

// File: rtl/ad9226_capture.sv
// AD9226 capture: generates ADC_CLK, samples the ADC bus, decimates, triggers and
// fills a DEPTH-sample buffer that is then drained through the read-strobe port.
module ad9226_capture #(
   parameter int DATA_W  = 12,
   parameter int ADDR_W  = 10,
   parameter int CLK_DIV = 4
) (
   input logic             Clk,
   input logic             Reset_n,
   ad9226_capture_if.slave bus
);
   localparam int DEPTH = 1 << ADDR_W;
   localparam int DIV_W = $clog2(CLK_DIV);
   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
   localparam logic [DIV_W-1:0]  DIV_HALF  = DIV_W'(CLK_DIV / 2);
   localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

   typedef enum logic [1:0] {S_IDLE, S_ARM, S_CAP, S_DONE} state_t;
   state_t state, state_nxt;

   logic [DIV_W-1:0]  div_cnt;
   logic              adc_clk, tick, smp_vld;
   logic [DATA_W-1:0] s_cur, s_prev;
   logic              otr_cur;
   logic              trig_mode_l, prev_ok;
   logic [DATA_W-1:0] trig_lvl_l;
   logic [15:0]       decim_l, dcnt;
   logic [ADDR_W-1:0] wr_addr, rd_addr, waddr;
   logic              start_ok, active, keep, trig_hit, we, rd_fire;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] rd_data;
   logic              rd_valid, busy, done, ovr;

   // ADC_CLK is registered so the pin never glitches; sampling happens on its falling edge
   always_ff @(posedge Clk or negedge Reset_n)
      if (!Reset_n) begin
         div_cnt <= '0;
         adc_clk <= 1'b0;
      end else begin
         div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
         if (div_cnt == '0)           adc_clk <= 1'b1;
         else if (div_cnt == DIV_HALF) adc_clk <= 1'b0;
      end

   assign tick = (div_cnt == DIV_HALF);

   always_ff @(posedge Clk or negedge Reset_n)
      if (!Reset_n) begin
         smp_vld <= 1'b0;
         s_cur   <= '0;
         s_prev  <= '0;
         otr_cur <= 1'b0;
      end else begin
         smp_vld <= tick;
         if (tick) begin
            s_cur   <= bus.ADC_Data;
            s_prev  <= s_cur;
            otr_cur <= bus.ADC_OTR;
         end
      end

   // Registered samples are consumed the cycle after the tick
   assign active   = (state == S_ARM) || (state == S_CAP);
   assign start_ok = bus.Start && ((state == S_IDLE) || (state == S_DONE));
   assign keep     = smp_vld && active && (dcnt == decim_l);
   assign trig_hit = !trig_mode_l ||
                     (prev_ok && (s_prev < trig_lvl_l) && (s_cur >= trig_lvl_l));
   assign we       = keep && ((state == S_CAP) || trig_hit);
   assign waddr    = (state == S_ARM) ? '0 : wr_addr;
   assign rd_fire  = (state == S_DONE) && bus.Rd_en && !bus.Start;

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (start_ok) state_nxt = S_ARM;
         S_ARM:  if (keep && trig_hit) state_nxt = S_CAP;
         S_CAP:  if (we && (wr_addr == ADDR_LAST)) state_nxt = S_DONE;
         S_DONE: if (start_ok) state_nxt = S_ARM;
                 else if (rd_fire && (rd_addr == ADDR_LAST)) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset_n)
      if (!Reset_n) begin
         state       <= S_IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         trig_mode_l <= 1'b0;
         trig_lvl_l  <= '0;
         decim_l     <= '0;
         dcnt        <= '0;
         prev_ok     <= 1'b0;
         wr_addr     <= '0;
         rd_addr     <= '0;
         ovr         <= 1'b0;
      end else begin
         state <= state_nxt;
         busy  <= (state_nxt == S_ARM) || (state_nxt == S_CAP);
         done  <= (state_nxt == S_DONE);
         if (start_ok) begin
            trig_mode_l <= bus.Trig_Mode;
            trig_lvl_l  <= bus.Trig_Level;
            decim_l     <= bus.Decim;
            dcnt        <= '0;
            prev_ok     <= 1'b0;
            wr_addr     <= '0;
            rd_addr     <= '0;
            ovr         <= 1'b0;
         end else begin
            if (smp_vld && active) dcnt <= keep ? '0 : dcnt + 1'b1;
            if (keep) prev_ok <= 1'b1;
            if (we) begin
               wr_addr <= waddr + 1'b1;
               if (otr_cur) ovr <= 1'b1;
            end
            if (rd_fire) rd_addr <= rd_addr + 1'b1;
         end
      end

   always_ff @(posedge Clk)
      if (we) mem[waddr] <= s_cur;

   always_ff @(posedge Clk or negedge Reset_n)
      if (!Reset_n) begin
         rd_data  <= '0;
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= rd_fire;
         if (rd_fire) rd_data <= mem[rd_addr];
      end

   assign bus.ADC_CLK  = adc_clk;
   assign bus.Rd_data  = rd_data;
   assign bus.Rd_valid = rd_valid;
   assign bus.Busy     = busy;
   assign bus.Done     = done;
   assign bus.Ovr      = ovr;
endmodule

// File: tb/tb_ad9226_capture.sv
// Bench for ad9226_capture: ramp ADC model, tick log and a buffer model built from
// the capture rules (decimation, trigger, DEPTH kept samples) checked on read-back.
module tb_ad9226_capture;
   localparam int DATA_W = 12;
   localparam int ADDR_W = 10;
   localparam int DEPTH  = 1 << ADDR_W;

   logic Clk = 1'b0;
   logic Reset_n = 1'b0;
   ad9226_capture_if #(.DATA_W(DATA_W)) bus();

   ad9226_capture #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CLK_DIV(4)) dut (
      .Clk(Clk), .Reset_n(Reset_n), .bus(bus)
   );

   always #4 Clk = ~Clk;

   // ADC model: a new ramp value (and OTR flag) after every rising ADC_CLK
   int unsigned adc_val = 0;
   bit          otr_all = 1'b0;
   int          otr_hit = -1;
   always @(posedge bus.ADC_CLK) begin
      bus.ADC_Data = DATA_W'(adc_val);
      bus.ADC_OTR  = otr_all || (int'(adc_val % 4096) == otr_hit);
      adc_val      = adc_val + 1;
   end

   typedef struct {int cyc; int data; bit otr;} tick_t;
   tick_t ticks[$];
   int    cyc = 0, start_cyc = 0, arm_cyc = 0;
   bit    adc_q = 1'b0;
   always @(posedge Clk) begin
      #1;
      cyc++;
      if (adc_q && !bus.ADC_CLK) ticks.push_back('{cyc, int'(bus.ADC_Data), bus.ADC_OTR});
      if (bus.Start) start_cyc = cyc;
      adc_q = bus.ADC_CLK;
   end

   int n_chk = 0, n_err = 0;
   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   bit cfg_mode;
   int cfg_lvl, cfg_dec, first_rd;
   int exp_buf [DEPTH];
   bit exp_ovr;

   task automatic arm(input bit mode, input int lvl, input int dec);
      @(negedge Clk);
      ticks.delete();
      cfg_mode = mode; cfg_lvl = lvl; cfg_dec = dec;
      bus.Trig_Mode = mode; bus.Trig_Level = DATA_W'(lvl); bus.Decim = 16'(dec);
      bus.Start = 1'b1;
      @(negedge Clk);
      bus.Start = 1'b0;
      arm_cyc = start_cyc;
      // config pins wander afterwards; only the Start-time values may matter
      bus.Trig_Mode = ~mode; bus.Trig_Level = DATA_W'($urandom); bus.Decim = 16'($urandom);
   endtask

   task automatic start_ignored();
      @(negedge Clk);
      bus.Trig_Mode = 1'b0; bus.Decim = 16'd0; bus.Trig_Level = '0; bus.Start = 1'b1;
      @(negedge Clk);
      bus.Start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      bit ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge Clk);
         if (bus.Done) begin ok = 1'b1; break; end
      end
      chk({tag, "_done"}, int'(ok), 1);
   endtask

   // Expected buffer: post-Start ticks, keep every (Decim+1)th, trigger rule, DEPTH samples
   task automatic build_model(input string tag);
      int  j = 0, nk = 0, n = 0;
      bit  cap = 1'b0;
      exp_ovr = 1'b0;
      for (int i = 0; i < ticks.size() && n < DEPTH; i++) begin
         if (ticks[i].cyc < arm_cyc) continue;
         j++;
         if (j % (cfg_dec + 1) != 0) continue;
         nk++;
         if (!cap)
            cap = !cfg_mode || (nk > 1 && ticks[i-1].data < cfg_lvl && ticks[i].data >= cfg_lvl);
         if (cap) begin
            exp_buf[n] = ticks[i].data;
            exp_ovr |= ticks[i].otr;
            n++;
         end
      end
      chk({tag, "_fill"}, n, DEPTH);
      chk({tag, "_ovr"}, int'(bus.Ovr), int'(exp_ovr));
      chk({tag, "_busy"}, int'(bus.Busy), 0);
   endtask

   task automatic read_n(input string tag, input int n);
      for (int i = 0; i <= n; i++) begin
         @(negedge Clk);
         if (i == 0) chk({tag, "_vld_pre"}, int'(bus.Rd_valid), 0);
         else begin
            if (i == 1) first_rd = int'(bus.Rd_data);
            chk({tag, "_vld"}, int'(bus.Rd_valid), 1);
            chk({tag, "_dat"}, int'(bus.Rd_data), exp_buf[i-1]);
         end
         bus.Rd_en = (i < n);
      end
      @(negedge Clk);
      chk({tag, "_vld_end"}, int'(bus.Rd_valid), 0);
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_busy"}, int'(bus.Busy), 0);
      chk({tag, "_done"}, int'(bus.Done), 0);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_adcclk"}, int'(bus.ADC_CLK), 0);
      chk({tag, "_rddata"}, int'(bus.Rd_data), 0);
      chk({tag, "_rdvld"}, int'(bus.Rd_valid), 0);
      chk({tag, "_busy"}, int'(bus.Busy), 0);
      chk({tag, "_done"}, int'(bus.Done), 0);
      chk({tag, "_ovr"}, int'(bus.Ovr), 0);
   endtask

   initial begin
      bit v [8];
      int ph, st, lv;
      bus.Start = 1'b0; bus.Rd_en = 1'b0; bus.Trig_Mode = 1'b0;
      bus.Trig_Level = '0; bus.Decim = '0;

      // 1: reset values, ADC_CLK shape, idle read ignored
      #20 chk_reset("t1_rst");
      @(negedge Clk); Reset_n = 1'b1;
      repeat (3) @(negedge Clk);
      for (int i = 0; i < 8; i++) begin v[i] = bus.ADC_CLK; @(negedge Clk); end
      ph = 0;
      for (int k = 3; k >= 0; k--) if (!v[k] && v[k+1]) ph = k + 1;
      for (int i = 0; i < 8; i++) chk("t1_adcclk", int'(v[i]), int'(((i - ph + 8) % 4) < 2));
      bus.Rd_en = 1'b1;
      repeat (3) @(negedge Clk);
      bus.Rd_en = 1'b0;
      chk("t1_idle_rdvld", int'(bus.Rd_valid), 0);
      chk("t1_idle_rddata", int'(bus.Rd_data), 0);
      chk_idle("t1_idle");

      // 2: ramp, mode 0, no decimation
      adc_val = 0;
      arm(1'b0, 0, 0);
      chk("t2_busy", int'(bus.Busy), 1);
      wait_done("t2", 6000);
      build_model("t2");
      read_n("t2_rd", DEPTH);
      chk_idle("t2_end");

      // 3: Decim = 3
      adc_val = 0;
      arm(1'b0, 0, 3);
      wait_done("t3", 20000);
      build_model("t3");
      read_n("t3_rd", DEPTH);
      chk_idle("t3_end");

      // 4: rising-level trigger from below, then from above (needs wrap), Start in ARM ignored
      adc_val = 'h700;
      arm(1'b1, 'h800, 0);
      wait_done("t4a", 6000);
      build_model("t4a");
      read_n("t4a_rd", DEPTH);
      chk("t4a_addr0", first_rd, 'h800);
      adc_val = 'h900;
      arm(1'b1, 'h800, 0);
      repeat (200) @(negedge Clk);
      chk("t4b_armed_busy", int'(bus.Busy), 1);
      start_ignored();
      repeat (200) @(negedge Clk);
      chk("t4b_still_busy", int'(bus.Busy), 1);
      chk("t4b_not_done", int'(bus.Done), 0);
      wait_done("t4b", 25000);
      build_model("t4b");
      read_n("t4b_rd", DEPTH);
      chk("t4b_addr0", first_rd, 'h800);

      // 5: OTR on one stored sample is sticky past the drain
      adc_val = 0; otr_hit = 'h200;
      arm(1'b0, 0, 0);
      wait_done("t5a", 6000);
      build_model("t5a");
      chk("t5a_ovr_set", int'(bus.Ovr), 1);
      read_n("t5a_rd", DEPTH);
      chk("t5a_ovr_hold", int'(bus.Ovr), 1);
      otr_hit = -1;

      // 5/6: OTR only while idle, restart from DONE after 10 reads
      otr_all = 1'b1;
      repeat (50) @(negedge Clk);
      otr_all = 1'b0;
      repeat (8) @(negedge Clk);
      adc_val = 'h123;
      arm(1'b0, 0, 0);
      chk("t5b_ovr_clr", int'(bus.Ovr), 0);
      wait_done("t5b", 6000);
      build_model("t5b");
      chk("t5b_ovr", int'(bus.Ovr), 0);
      read_n("t6_rd10", 10);
      adc_val = 'hA00;
      arm(1'b0, 0, 1);
      chk("t6_rearm_busy", int'(bus.Busy), 1);
      chk("t6_rearm_done", int'(bus.Done), 0);
      wait_done("t6", 10000);
      build_model("t6");
      read_n("t6_rd", DEPTH);

      // 6: reset mid-capture
      otr_all = 1'b1;
      arm(1'b0, 0, 0);
      repeat (300) @(negedge Clk);
      chk("t6r_busy", int'(bus.Busy), 1);
      chk("t6r_ovr", int'(bus.Ovr), 1);
      Reset_n = 1'b0;
      #1 chk_reset("t6r_rst");
      otr_all = 1'b0;
      @(negedge Clk); @(negedge Clk); Reset_n = 1'b1;
      repeat (20) @(negedge Clk);
      chk_idle("t6r_after");

      // randomized runs
      adc_val = $urandom % 4096;
      arm(1'b0, 0, int'($urandom_range(0, 1)));
      wait_done("r0", 10000);
      build_model("r0");
      read_n("r0_rd", DEPTH);
      st = int'($urandom % 4096);
      lv = (st + int'($urandom_range(4, 200))) % 4096;
      if (lv == 0) lv = 1;
      adc_val = st;
      arm(1'b1, lv, 0);
      wait_done("r1", 6000);
      build_model("r1");
      read_n("r1_rd", DEPTH);
      chk("r1_addr0", first_rd, lv);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end
endmodule
